control_unit: RTL and testbench
===============================

# control_unit

Finite-state controller that sequences the 8-bit accumulator datapath `DP` through fetch, decode and execute for the 3-bit-opcode instruction set. It receives `IR`, `Aeq0` and `Apos` from `DP` and drives all of its control inputs. It also handles the Enter handshake for `IN` and reports halt and state to the board.

## Interface
Parameters:
- `STATE_W`, 4, width of the state register and of the `State` debug output.

Ports:
- `Clock`  in  1  single system clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high; returns the FSM to START at the next rising edge.
- `IR`  in  3  opcode bits IR[7:5] from `DP`.
- `Aeq0`  in  1  accumulator equals zero.
- `Apos`  in  1  accumulator positive (bit 7 = 0, A ≠ 0).
- `Enter`  in  1  operator Enter key, already synchronous to `Clock`.
- `IRload`, `JMPmux`, `PCload`, `Meminst`, `MemWr`, `Aload`, `Sub`  out  1 each  `DP` controls.
- `Asel`  out  2  A-input mux: 00 = add/sub result, 01 = INPUT, 10 = memory.
- `Halt`  out  1  high in HALT.
- `State`  out  STATE_W  current state encoding, for LEDs.

## Operation
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 IN, 101 JZ, 110 JPOS, 111 HALT.
- States and encodings:
  - START 0000
  - FETCH 0001
  - DECODE 0010
  - LOAD 1000
  - STORE 1001
  - ADD 1010
  - SUB 1011
  - INPUT 1100
  - JZ 1101
  - JPOS 1110
  - HALT 1111
- Transitions:
  - START → FETCH.
  - FETCH → DECODE.
  - DECODE → the execute state selected by `IR`.
  - LOAD, STORE, ADD, SUB, JZ, JPOS → FETCH.
  - INPUT → FETCH on `enter_pulse`; otherwise stays in INPUT.
  - HALT → HALT; it is left only through Reset.
- Outputs per state. Any control not listed is 0; `Asel` defaults to 00.
  - START: all 0.
  - FETCH: `IRload`=1, `PCload`=1; PC addresses memory and increments.
  - DECODE: `Meminst`=1, so memory is addressed by IR[4:0] ahead of execute.
  - LOAD: `Meminst`=1, `Asel`=10, `Aload`=1.
  - STORE: `Meminst`=1, `MemWr`=1.
  - ADD: `Meminst`=1, `Asel`=00, `Aload`=1, `Sub`=0.
  - SUB: the same as ADD, but with `Sub`=1.
  - INPUT: `Asel`=01, `Aload`=`enter_pulse`.
  - JZ: `JMPmux`=1, `PCload`=`Aeq0`.
  - JPOS: `JMPmux`=1, `PCload`=`Apos`.
  - HALT: `Halt`=1.
- `enter_pulse` = `Enter` & ~`enter_q`, where `enter_q` is `Enter` registered every cycle (reset 0).
  - A held Enter therefore satisfies only one IN instruction.
  - A second IN needs Enter to be released and pressed again.
- Outputs are decoded from the state register. The Mealy terms are limited to `PCload` in JZ/JPOS and `Aload` in INPUT.

## Timing
- Reset behaviour:
  - With `Reset` high at a rising edge: state becomes START and `enter_q` becomes 0. All outputs are 0 and `State`=0000 from that edge onward.
  - During the cycle in which `Reset` is first sampled, outputs still reflect the pre-reset state; the reset is synchronous.
  - Reset mid-instruction, including mid-STORE, aborts the instruction at the next edge. A `MemWr` already asserted in that cycle still completes its write.
- After `Reset` falls: START for 1 cycle, then FETCH on the next cycle.
- Instruction lengths:
  - Non-IN instructions take exactly 3 cycles: FETCH, DECODE, execute.
  - IN takes 3 + N cycles, where N is the number of cycles spent waiting for `enter_pulse`.
- `IR` is sampled only in DECODE, one cycle after the `IRload` edge. `Aeq0`/`Apos` are sampled only in JZ/JPOS and reflect A as of the last `Aload` edge.
- A `Reset` and `enter_pulse` in the same cycle: Reset wins and A is not loaded.

## Structure
- Package `cu_pkg`: state localparams, opcode constants (OP_LOAD … OP_HALT) and `Asel` codes (ASEL_ALU, ASEL_IN, ASEL_MEM). The same package is shared with `DP` and the top level.
- One sub-module, `edge_detect`: registered rising-edge detector with synchronous active-high reset, used for `Enter`.
- The FSM uses one state register, a next-state case block and an output case block.

## Test plan
- Reset held 3 cycles, then released: all outputs 0 with `State`=0000 while held; START for 1 cycle after release; then FETCH with `IRload`=`PCload`=1.
- `IR`=000 at DECODE: the next cycle is LOAD with `Meminst`=1, `Asel`=10, `Aload`=1; FETCH follows.
- `IR`=100, `Enter` low for 4 cycles, then held high for 5 cycles:
  - the FSM stays in INPUT 4 cycles with `Aload`=0;
  - `Aload`=1 for exactly 1 cycle, then FETCH.
  - A second `IR`=100 with `Enter` still held waits in INPUT until Enter is re-pressed.
- `IR`=101: `Aeq0`=1 gives `JMPmux`=1, `PCload`=1; `Aeq0`=0 gives `JMPmux`=1, `PCload`=0.
- `IR`=110 with `Apos`=1 gives `PCload`=1. `IR`=011 gives SUB with `Sub`=1, `Asel`=00, `Aload`=1.
- `IR`=111 gives HALT: `Halt`=1 held for 10+ cycles regardless of `Enter`. `Reset` pulsed during STORE gives START at the next edge, then normal FETCH.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator machine: controller state codes,
// opcode constants and A-input mux select codes.
package cu_pkg;

  // Controller states; execute states are 1 followed by the opcode.
  typedef enum logic [3:0] {
    ST_START  = 4'b0000,
    ST_FETCH  = 4'b0001,
    ST_DECODE = 4'b0010,
    ST_LOAD   = 4'b1000,
    ST_STORE  = 4'b1001,
    ST_ADD    = 4'b1010,
    ST_SUB    = 4'b1011,
    ST_INPUT  = 4'b1100,
    ST_JZ     = 4'b1101,
    ST_JPOS   = 4'b1110,
    ST_HALT   = 4'b1111
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Execute state for an opcode: the encoding places the opcode under a leading 1.
  function automatic state_t exec_state(input logic [2:0] op);
    return state_t'({1'b1, op});
  endfunction

endpackage

// File: rtl/control_unit_edge_detect.sv
// Registered rising-edge detector with synchronous active-high reset.
// The pulse is high in the first cycle the input is seen high.
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_pulse
);

  logic r_q;

  // Delay the input by one cycle so a held level produces a single pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_pulse = i_d & ~r_q;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller for the 8-bit accumulator datapath.
// Outputs are decoded from the state register; only PCload in JZ/JPOS and
// Aload in INPUT depend on live inputs.
module control_unit
  import cu_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [2:0]         IR,
  input  logic               Aeq0,
  input  logic               Apos,
  input  logic               Enter,
  output logic               IRload,
  output logic               JMPmux,
  output logic               PCload,
  output logic               Meminst,
  output logic               MemWr,
  output logic               Aload,
  output logic               Sub,
  output logic [1:0]         Asel,
  output logic               Halt,
  output logic [STATE_W-1:0] State
);

  state_t r_state;
  state_t w_next;
  logic   w_enter_pulse;

  edge_detect u_enter_edge (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_d     (Enter),
    .o_pulse (w_enter_pulse)
  );

  // State register with synchronous reset back to START.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_START;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection; HALT is only left through Reset.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_START:  w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = exec_state(IR);
      ST_INPUT: begin
        if (w_enter_pulse) begin
          w_next = ST_FETCH;
        end else begin
          w_next = ST_INPUT;
        end
      end
      ST_HALT:   w_next = ST_HALT;
      ST_LOAD, ST_STORE, ST_ADD, ST_SUB, ST_JZ, ST_JPOS: w_next = ST_FETCH;
      default:   w_next = ST_START;
    endcase
  end

  // Datapath control decode per state; a pending Reset blocks the INPUT load.
  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = ASEL_ALU;
    Halt    = 1'b0;
    case (r_state)
      ST_START: begin
      end
      ST_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      ST_DECODE: Meminst = 1'b1;
      ST_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_MEM;
        Aload   = 1'b1;
      end
      ST_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      ST_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      ST_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      ST_INPUT: begin
        Asel  = ASEL_IN;
        Aload = w_enter_pulse & ~Reset;
      end
      ST_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      ST_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      ST_HALT: Halt = 1'b1;
      default: begin
      end
    endcase
  end

  assign State = STATE_W'(r_state);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps following the test
// plan, then random stimulus, all checked against an instruction-level model.
module tb_control_unit;

  logic       Clock = 1'b0;
  logic       Reset, Aeq0, Apos, Enter;
  logic [2:0] IR;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;

  control_unit #(.STATE_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos),
    .Enter(Enter), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload), .Sub(Sub),
    .Asel(Asel), .Halt(Halt), .State(State)
  );

  always #5 Clock = ~Clock;

  // Model: phase 0 = start, 1 = fetch, 2 = decode, 3 = executing m_op.
  int       m_phase = 0;
  int       m_op = 0;
  bit       m_enter_prev = 1'b0;
  bit       m_valid = 1'b0;
  int       n_assert = 0;
  int       n_fail = 0;
  int       n_cyc = 0;

  logic [9:0] w_obs, w_exp;
  logic [3:0] w_state_exp;

  // Expected {IRload,JMPmux,PCload,Meminst,MemWr,Aload,Sub,Asel,Halt}.
  function automatic logic [9:0] expect_ctrl(int ph, int op, bit rst, bit a0,
                                             bit ap, bit en, bit prev);
    bit pulse;
    pulse = en & ~prev;
    case (ph)
      1: return 10'b1010000000;
      2: return 10'b0001000000;
      3: begin
        case (op)
          0: return 10'b0001010100;
          1: return 10'b0001100000;
          2: return 10'b0001010000;
          3: return 10'b0001011000;
          4: return {5'b00000, pulse & ~rst, 1'b0, 2'b01, 1'b0};
          5: return {2'b01, a0, 7'b0000000};
          6: return {2'b01, ap, 7'b0000000};
          default: return 10'b0000000001;
        endcase
      end
      default: return 10'b0000000000;
    endcase
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    @(negedge Clock);
    n_cyc++;
    if (m_valid) begin
      w_obs = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt};
      w_exp = expect_ctrl(m_phase, m_op, Reset, Aeq0, Apos, Enter, m_enter_prev);
      w_state_exp = (m_phase == 3) ? 4'(8 + m_op) : 4'(m_phase);
      n_assert++;
      assert (w_obs === w_exp) else begin
        n_fail++;
        $error("FAIL ctrl cyc=%0d observed=%b expected=%b", n_cyc, w_obs, w_exp);
      end
      n_assert++;
      assert (State === w_state_exp) else begin
        n_fail++;
        $error("FAIL state cyc=%0d observed=%b expected=%b", n_cyc, State, w_state_exp);
      end
    end
    @(posedge Clock);
    if (Reset) begin
      m_phase = 0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: m_phase = 2;
        2: begin
          m_phase = 3;
          m_op = int'(IR);
        end
        default: begin
          if (m_op == 4) m_phase = (Enter && !m_enter_prev) ? 1 : 3;
          else if (m_op != 7) m_phase = 1;
        end
      endcase
    end
    m_enter_prev = Reset ? 1'b0 : Enter;
    #1;
  endtask

  // Fetch, decode with the given opcode, then one execute cycle.
  task automatic run_op(input logic [2:0] op, input logic a0, input logic ap);
    Aeq0 = a0;
    Apos = ap;
    IR = 3'b000;
    tick();
    IR = op;
    tick();
    IR = 3'b000;
    tick();
  endtask

  initial begin
    Reset = 1'b1; IR = 3'b000; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
    repeat (4) tick();
    Reset = 1'b0;
    tick();                                  // START
    run_op(3'b000, 1'b0, 1'b0);              // LOAD
    run_op(3'b001, 1'b0, 1'b0);              // STORE
    // IN: Enter low for 4 waiting cycles, then held high
    tick();
    IR = 3'b100;
    tick();
    repeat (4) tick();
    Enter = 1'b1;
    tick();                                  // Aload pulse
    tick();                                  // FETCH
    tick();                                  // DECODE of second IN
    repeat (2) tick();                       // waiting, Enter still held
    Enter = 1'b0;
    tick();
    Enter = 1'b1;
    tick();                                  // re-press loads A
    Enter = 1'b0;
    run_op(3'b101, 1'b1, 1'b0);
    run_op(3'b101, 1'b0, 1'b0);
    run_op(3'b110, 1'b0, 1'b1);
    run_op(3'b110, 1'b0, 1'b0);
    run_op(3'b011, 1'b0, 1'b0);
    run_op(3'b010, 1'b0, 1'b0);
    // Reset during STORE
    tick();
    IR = 3'b001;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    run_op(3'b000, 1'b0, 1'b0);
    // HALT holds regardless of Enter
    run_op(3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      Enter = i[0];
      tick();
    end
    Reset = 1'b1; Enter = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    // Reset coinciding with an Enter pulse in INPUT
    tick();
    IR = 3'b100;
    tick();
    tick();
    Reset = 1'b1; Enter = 1'b1;
    tick();
    Reset = 1'b0; Enter = 1'b0;
    tick();
    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(0, 24) == 0);
      IR    = 3'($urandom_range(0, 7));
      Aeq0  = 1'($urandom_range(0, 1));
      Apos  = 1'($urandom_range(0, 1));
      Enter = ($urandom_range(0, 2) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
